out_write_queue: RTL and testbench

//   Buffers display-write requests from the CPU in a DEPTH-entry FIFO (valid/ready).

---
 rtl/out_write_queue.sv | 165 ++++++++++++++++
 tb/tb_out_write_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/out_write_queue.sv
// out_write_queue: buffers display-write requests in a DEPTH-entry FIFO and
// drains them one at a time as a single-cycle outdisplay strobe, followed by
// GAP idle cycles, for the downstream 8-slot hex display driver.
//
// Optional build macro OUT_COALESCE_EN: a push that targets the same display
// slot as the newest still-queued entry overwrites that entry's values in
// place instead of allocating a new one.
//
// state  | meaning
// IDLE   | waiting for a queued entry; pops head when count != 0
// PULSE  | outdisplay high this cycle; schedules the idle gap
// WAIT   | counting down gap_cnt idle cycles before the next pop
module out_write_queue #(
  parameter int DEPTH = 8,
  parameter int GAP   = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [15:0]              wr_val1,
  input  logic [15:0]              wr_val2,
  input  logic [2:0]               wr_sel,
  output logic [15:0]              outval1,
  output logic [15:0]              outval2,
  output logic [2:0]               outsel,
  output logic                     outdisplay,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_WAIT} state_t;

  state_t         state_q, state_d;
  logic [3:0]     gap_cnt, gap_d;
  logic [15:0]    mem_v1 [DEPTH];
  logic [15:0]    mem_v2 [DEPTH];
  logic [2:0]     mem_sel [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, last_ptr;
  logic           push, pop, alloc, coalesce;

  // Ready depends only on registered occupancy, never on a same-edge pop.
  assign wr_ready = (count != CNT_FULL);
  assign push     = wr_valid && wr_ready;
  assign alloc    = push && !coalesce;
  assign last_ptr = wr_ptr - 1'b1;

`ifdef OUT_COALESCE_EN
  logic [2:0] last_sel;
  logic       last_vld;

  // The newest entry is being popped this edge exactly when it is the only one.
  assign coalesce = push && last_vld && (wr_sel == last_sel) && !(pop && count == CNT_ONE);

  // Track the slot of the newest queued entry while it is still in the FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_sel <= '0;
      last_vld <= 1'b0;
    end else if (alloc) begin
      last_sel <= wr_sel;
      last_vld <= 1'b1;
    end else if (pop && count == CNT_ONE) begin
      last_vld <= 1'b0;
    end
  end
`else
  assign coalesce = 1'b0;
`endif

  // Entry storage: new entries at wr_ptr, coalesced writes patch the newest one.
  always_ff @(posedge clock) begin
    if (alloc) begin
      mem_v1[wr_ptr]  <= wr_val1;
      mem_v2[wr_ptr]  <= wr_val2;
      mem_sel[wr_ptr] <= wr_sel;
    end else if (coalesce) begin
      mem_v1[last_ptr] <= wr_val1;
      mem_v2[last_ptr] <= wr_val2;
    end
  end

  // Pointers and occupancy; simultaneous alloc and pop leave count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (alloc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (alloc && !pop)      count <= count + 1'b1;
      else if (!alloc && pop) count <= count - 1'b1;
    end
  end

  // Drain sequencer next-state: pop from IDLE, strobe, then GAP idle cycles.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_cnt;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d   = 4'(GAP - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (gap_cnt == 4'd0) state_d = ST_IDLE;
        else                 gap_d   = gap_cnt - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state register and gap down-counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gap_cnt <= '0;
    end else begin
      state_q <= state_d;
      gap_cnt <= gap_d;
    end
  end

  // Output registers hold the last popped entry; strobe only on the pop edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outval1    <= '0;
      outval2    <= '0;
      outsel     <= '0;
      outdisplay <= 1'b0;
    end else begin
      outdisplay <= pop;
      if (pop) begin
        outval1 <= mem_v1[rd_ptr];
        outval2 <= mem_v2[rd_ptr];
        outsel  <= mem_sel[rd_ptr];
      end
    end
  end

  // Sticky overflow; a new stall wins over a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      overflow <= 1'b0;
    else if (wr_valid && !wr_ready) overflow <= 1'b1;
    else if (clr_ovf)               overflow <= 1'b0;
  end

endmodule

// File: tb/tb_out_write_queue.sv
// tb_out_write_queue: directed bench for out_write_queue (DEPTH=8). Main
// instance uses GAP=3; a second instance with GAP=0 covers pointer wrap.
module tb_out_write_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_valid, wr_valid_g0;
  logic        wr_ready, wr_ready_g0;
  logic [15:0] wr_val1, wr_val2;
  logic [2:0]  wr_sel;
  logic [15:0] outval1, outval2, outval1_g0, outval2_g0;
  logic [2:0]  outsel, outsel_g0;
  logic        outdisplay, outdisplay_g0;
  logic [3:0]  count, count_g0;
  logic        overflow, overflow_g0;
  logic        clr_ovf;

  typedef struct {
    int          cyc;
    logic [2:0]  sel;
    logic [15:0] v1;
    logic [15:0] v2;
  } strobe_t;

  strobe_t sq[$];
  strobe_t sq0[$];
  int cyc = 0;
  int last_acc = 0;
  int maxcnt0 = 0;
  int checks = 0;
  int errors = 0;

`ifdef OUT_COALESCE_EN
  localparam int T5_N = 2;
`else
  localparam int T5_N = 3;
`endif

  out_write_queue #(.DEPTH(8), .GAP(3)) dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_val1(wr_val1), .wr_val2(wr_val2), .wr_sel(wr_sel),
    .outval1(outval1), .outval2(outval2), .outsel(outsel),
    .outdisplay(outdisplay), .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  out_write_queue #(.DEPTH(8), .GAP(0)) dut_g0 (
    .clock(clock), .reset(reset), .wr_valid(wr_valid_g0), .wr_ready(wr_ready_g0),
    .wr_val1(wr_val1), .wr_val2(wr_val2), .wr_sel(wr_sel),
    .outval1(outval1_g0), .outval2(outval2_g0), .outsel(outsel_g0),
    .outdisplay(outdisplay_g0), .count(count_g0), .overflow(overflow_g0), .clr_ovf(clr_ovf)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Record every strobe with the edge index it followed.
  always @(negedge clock) begin
    if (outdisplay)    sq.push_back('{cyc, outsel, outval1, outval2});
    if (outdisplay_g0) sq0.push_back('{cyc, outsel_g0, outval1_g0, outval2_g0});
    if (int'(count_g0) > maxcnt0) maxcnt0 = int'(count_g0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_write(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    wr_valid = 1'b1; wr_sel = s; wr_val1 = a; wr_val2 = b;
    while (!wr_ready && n < 100) begin @(negedge clock); n++; end
    chk("wr_accept", {31'd0, wr_ready}, 32'd1);
    last_acc = cyc + 1;
    @(negedge clock);
    wr_valid = 1'b0;
  endtask

  task automatic do_write_g0(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    wr_valid_g0 = 1'b1; wr_sel = s; wr_val1 = a; wr_val2 = b;
    while (!wr_ready_g0 && n < 100) begin @(negedge clock); n++; end
    chk("g0_accept", {31'd0, wr_ready_g0}, 32'd1);
    @(negedge clock);
    wr_valid_g0 = 1'b0;
  endtask

  task automatic wait_sq(input int n);
    int k = 0;
    while (sq.size() < n && k < 500) begin @(negedge clock); k++; end
    chk("strobe_cnt", sq.size(), n);
  endtask

  // Ten writes from idle fill the queue exactly; one extra stalled cycle sets overflow.
  task automatic burst_stall(input logic [15:0] base, input logic clr);
    for (int i = 0; i < 10; i++) do_write(3'(i), base + 16'(i), ~(base + 16'(i)));
    chk("full_cnt", count, 8);
    chk("full_rdy", wr_ready, 0);
    wr_valid = 1'b1; clr_ovf = clr;
    @(negedge clock);
    wr_valid = 1'b0; clr_ovf = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("stall_cnt", count, 8);
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_valid_g0 = 1'b0; clr_ovf = 1'b0;
    wr_sel = '0; wr_val1 = '0; wr_val2 = '0;
    repeat (2) @(negedge clock);
    chk("rst_val1", outval1, 0);
    chk("rst_val2", outval2, 0);
    chk("rst_sel", outsel, 0);
    chk("rst_disp", outdisplay, 0);
    chk("rst_cnt", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rdy", wr_ready, 1);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // single write
    sq.delete();
    do_write(3'd5, 16'h1234, 16'hABCD);
    wait_sq(1);
    chk("t1_lat", sq[0].cyc - last_acc, 1);
    chk("t1_sel", sq[0].sel, 5);
    chk("t1_v1", sq[0].v1, 16'h1234);
    chk("t1_v2", sq[0].v2, 16'hABCD);
    repeat (10) @(negedge clock);
    chk("t1_n", sq.size(), 1);
    chk("t1_cnt", count, 0);
    chk("t1_hold_sel", outsel, 5);
    chk("t1_hold_v1", outval1, 16'h1234);
    chk("t1_hold_disp", outdisplay, 0);

    // eight back-to-back writes, strobes GAP+2 apart
    sq.delete();
    for (int i = 0; i < 8; i++) begin
      do_write(3'(i), 16'h2000 + 16'(i), 16'h2100 + 16'(i));
      if (i == 0) chk("t2_rdy0", wr_ready, 1);
    end
    wait_sq(8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_sel", sq[i].sel, i);
      chk("t2_gap", sq[i].cyc - sq[0].cyc, 5 * i);
    end
    repeat (10) @(negedge clock);
    chk("t2_ovf", overflow, 0);

    // fill, overflow, ordered drain, clear, set-wins-over-clear
    sq.delete();
    burst_stall(16'h3000, 1'b0);
    wait_sq(10);
    for (int i = 0; i < 10; i++) chk("t3_order", sq[i].v1, 16'h3000 + i);
    repeat (6) @(negedge clock);
    chk("t3_ovf_hold", overflow, 1);
    clr_ovf = 1'b1;
    @(negedge clock);
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", overflow, 0);
    sq.delete();
    burst_stall(16'h3100, 1'b1);
    wait_sq(10);
    chk("t3b_last", sq[9].v1, 16'h3109);
    repeat (6) @(negedge clock);
    clr_ovf = 1'b1;
    @(negedge clock);
    clr_ovf = 1'b0;

    // reset while the sequencer waits out its gap
    sq.delete();
    do_write(3'd1, 16'h4001, 16'h4101);
    do_write(3'd2, 16'h4002, 16'h4102);
    do_write(3'd3, 16'h4003, 16'h4103);
    wait_sq(1);
    #1 reset = 1'b1;
    #1;
    chk("t4_val1", outval1, 0);
    chk("t4_sel", outsel, 0);
    chk("t4_cnt", count, 0);
    chk("t4_disp", outdisplay, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("t4_nostrobe", sq.size(), 1);

    // same-slot writes while busy
    sq.delete();
    do_write(3'd6, 16'h5006, 16'h5106);
    do_write(3'd2, 16'h1111, 16'hAAAA);
    do_write(3'd2, 16'h2222, 16'hBBBB);
    wait_sq(T5_N);
    repeat (20) @(negedge clock);
    chk("t5_n", sq.size(), T5_N);
    chk("t5_first", sq[0].sel, 6);
    chk("t5_sel1", sq[1].sel, 2);
`ifdef OUT_COALESCE_EN
    chk("t5_v1", sq[1].v1, 16'h2222);
    chk("t5_v2", sq[1].v2, 16'hBBBB);
`else
    chk("t5_v1a", sq[1].v1, 16'h1111);
    chk("t5_v1b", sq[2].v1, 16'h2222);
    chk("t5_v2b", sq[2].v2, 16'hBBBB);
`endif

    // GAP=0 streaming across pointer wrap
    maxcnt0 = 0;
    sq0.delete();
    for (int i = 0; i < 27; i++) do_write_g0(3'(i), 16'h6000 + 16'(i), 16'h9000 + 16'(i));
    begin
      int k = 0;
      while (sq0.size() < 27 && k < 500) begin @(negedge clock); k++; end
    end
    chk("t6_n", sq0.size(), 27);
    for (int i = 0; i < 27; i++) begin
      chk("t6_v1", sq0[i].v1, 16'h6000 + i);
      chk("t6_sel", sq0[i].sel, i % 8);
    end
    chk("t6_gap", sq0[1].cyc - sq0[0].cyc, 2);
    chk("t6_max", maxcnt0, 8);
    repeat (4) @(negedge clock);
    chk("t6_cnt", count_g0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
